carry_save_adder: RTL and testbench
===================================

// Module: carry_save_adder
// PURPOSE
//   Registered 3:2 carry-save adder (compressor) for the arithmetic datapath.
//   Reduces three WIDTH-bit operands to a sum vector and a carry vector without carry propagation.
//   Also provides the resolved total as a registered-domain convenience output.
//   Serves as the reduction stage ahead of multiplier and accumulator carry-propagate adders.
// PARAMETERS
//   WIDTH  16  operand, sum and carry vector width in bits (>= 2)
// PORTS
//   clk        in   1          single clock, rising-edge
//   rst        in   1          reset, asynchronous, active-high
//   in_valid   in   1          a/b/c qualify this cycle
//   a          in   WIDTH      operand A, unsigned
//   b          in   WIDTH      operand B, unsigned
//   c          in   WIDTH      operand C, unsigned
//   out_valid  out  1          sum/carry/total hold a result
//   sum        out  WIDTH      bitwise partial sum: a ^ b ^ c
//   carry      out  WIDTH      bitwise majority (a&b)|(a&c)|(b&c), UNSHIFTED; bit i weighs 2^(i+1)
//   total      out  WIDTH+2    resolved sum: sum + (carry << 1), zero-extended
// BEHAVIOUR
//   - One clock, one asynchronous active-high reset (rst); no other resets or enables.
//   - rst asserted: out_valid, sum, carry and total clear to 0 immediately, without waiting for clk.
//   - rst held: all outputs stay 0 and inputs are ignored.
//   - First capture happens on the first rising clk edge after rst deasserts.
//   - Latency is exactly 1 cycle, with no stall and no backpressure.
//   - On each rising clk edge with in_valid=1:
//       sum   <= a ^ b ^ c
//       carry <= (a&b) | (a&c) | (b&c)
//       out_valid <= 1
//   - On each rising clk edge with in_valid=0:
//       out_valid <= 0
//       sum and carry hold their last values
//   - total is combinational from the registered sum and carry:
//       total = {2'b0, sum} + {1'b0, carry, 1'b0}
//     It is therefore aligned with out_valid.
//   - Invariant whenever out_valid=1:
//       sum + 2*carry == a + b + c  (exact, over WIDTH+2 bits)
//   - No overflow or wrap-around:
//       carry keeps the carry-out of the MSB in carry[WIDTH-1].
//       Maximum total is 3*(2^WIDTH - 1), which fits in WIDTH+2 bits.
//   - Arithmetic is unsigned throughout; there is no saturation.
//   - Back-to-back in_valid accepts a new triple every cycle; each result appears the following cycle.
//   - rst asserted mid-stream discards any in-flight result.
// TESTING
//   - Reset: rst=1 with random a/b/c -> sum=0, carry=0, total=0, out_valid=0.
//     rst is released asynchronously; outputs must stay 0 until the first valid capture.
//   - a=10, b=5, c=7, in_valid=1 -> next cycle:
//     sum=8, carry=7, total=22, out_valid=1.
//   - a=255, b=128, c=1 -> sum=126, carry=129, total=384.
//     Also a=32767, b=1, c=1 -> sum=32767, carry=1, total=32769.
//   - Edges:
//       a=65535, b=0, c=0         -> sum=65535, carry=0, total=65535
//       a=b=c=65535               -> sum=65535, carry=65535, total=196605
//       a=b=c=0                   -> all outputs 0
//   - a=12345, b=54321, c=11111 -> sum=53103, carry=12337, total=77777.
//     Then run 1000 random back-to-back triples, checking sum+2*carry==a+b+c one cycle later.
//   - Drop in_valid for 3 cycles:
//       out_valid falls after 1 cycle; sum and carry hold.
//     Assert rst mid-burst:
//       outputs clear at once; the next in_valid restarts normally.

Source files
------------

// File: rtl/carry_save_adder.sv
`default_nettype none
// ============================================================================
// Module      : carry_save_adder
// Description : Registered 3:2 carry-save compressor. Reduces three unsigned
//               WIDTH-bit operands to a bitwise sum vector and an unshifted
//               carry vector in one clock, with no carry propagation on the
//               registered path. A resolved total is derived combinationally
//               from the registered vectors, so it lines up with out_valid.
// Ports       :
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous active-high reset
//   in_valid   in   1         a/b/c qualify this cycle
//   a, b, c    in   WIDTH     unsigned operands
//   out_valid  out  1         sum/carry/total hold a result
//   sum        out  WIDTH     a ^ b ^ c
//   carry      out  WIDTH     majority(a,b,c); bit i weighs 2^(i+1)
//   total      out  WIDTH+2   sum + (carry << 1), zero-extended
// Revision    : 1.0 - initial release
// ============================================================================
module carry_save_adder #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               out_valid,
  output logic [WIDTH-1:0]   sum,
  output logic [WIDTH-1:0]   carry,
  output logic [WIDTH+1:0]   total
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH+1:0] w_total;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;

  // Full-adder per bit position, no ripple between positions.
  assign w_sum   = a ^ b ^ c;
  assign w_carry = (a & b) | (a & c) | (b & c);

  // sum and carry are only loaded on valid cycles; they hold otherwise so
  // the last result stays observable while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  // Carry is stored unshifted; the shift happens here so the MSB carry-out
  // lands in bit WIDTH and nothing is lost. Two extra bits cover 3*(2^W-1).
  assign w_total = {2'b00, r_sum} + {1'b0, r_carry, 1'b0};

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign total     = w_total;

endmodule
`default_nettype wire

// File: tb/tb_carry_save_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_save_adder
// Description : Self-checking bench for carry_save_adder (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_save_adder;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a, b, c;
  logic          out_valid;
  logic [W-1:0]  sum, carry;
  logic [W+1:0]  total;

  int n_checks = 0;
  int n_pass   = 0;

  carry_save_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .total     (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, c;
    logic [W-1:0] s, cy;
    logic [W+1:0] t;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs are driven just after a rising edge; the call returns 1 time unit
  // after the following edge, where the captured result is visible.
  task automatic apply(input logic v, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] vc);
    in_valid = v; a = va; b = vb; c = vc;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".sum"},       64'(sum),       64'd0);
    chk({tag, ".carry"},     64'(carry),     64'd0);
    chk({tag, ".total"},     64'(total),     64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc;
    logic [W-1:0] hs, hc;
    logic [W+1:0] ref_total;

    tbl[0] = '{a:16'd10,    b:16'd5,     c:16'd7,     s:16'd8,     cy:16'd7,     t:18'd22};
    tbl[1] = '{a:16'd255,   b:16'd128,   c:16'd1,     s:16'd126,   cy:16'd129,   t:18'd384};
    tbl[2] = '{a:16'd32767, b:16'd1,     c:16'd1,     s:16'd32767, cy:16'd1,     t:18'd32769};
    tbl[3] = '{a:16'd65535, b:16'd0,     c:16'd0,     s:16'd65535, cy:16'd0,     t:18'd65535};
    tbl[4] = '{a:16'd65535, b:16'd65535, c:16'd65535, s:16'd65535, cy:16'd65535, t:18'd196605};
    tbl[5] = '{a:16'd0,     b:16'd0,     c:16'd0,     s:16'd0,     cy:16'd0,     t:18'd0};
    tbl[6] = '{a:16'd12345, b:16'd54321, c:16'd11111, s:16'd53103, cy:16'd12337, t:18'd77777};

    // ---------------- reset with active-looking inputs ----------------
    rst = 1'b1; in_valid = 1'b1;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
    end
    chk_zero("reset");
    // Release reset away from any edge, inputs idle: outputs stay cleared.
    in_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("post_release");

    // ---------------- directed table ----------------
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, tbl[i].a, tbl[i].b, tbl[i].c);
      chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d.sum", i),       64'(sum),       64'(tbl[i].s));
      chk($sformatf("tbl%0d.carry", i),     64'(carry),     64'(tbl[i].cy));
      chk($sformatf("tbl%0d.total", i),     64'(total),     64'(tbl[i].t));
    end

    // ---------------- random back-to-back ----------------
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      apply(1'b1, ra, rb, rc);
      ref_total = (W+2)'(ra) + (W+2)'(rb) + (W+2)'(rc);
      chk("rnd.out_valid", 64'(out_valid), 64'd1);
      chk("rnd.sum",       64'(sum),       64'(ra ^ rb ^ rc));
      // Carry vector must supply exactly the remainder of the true sum.
      chk("rnd.carry",     64'(carry),     64'((ref_total - (W+2)'(ra ^ rb ^ rc)) >> 1));
      chk("rnd.invariant", 64'(sum) + 64'(2) * 64'(carry), 64'(ref_total));
      chk("rnd.total",     64'(total),     64'(ref_total));
    end

    // ---------------- in_valid dropped for 3 cycles ----------------
    apply(1'b1, 16'd10, 16'd5, 16'd7);
    hs = 16'd8; hc = 16'd7;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, W'($urandom), W'($urandom), W'($urandom));
      chk($sformatf("hold%0d.out_valid", i), 64'(out_valid), 64'd0);
      chk($sformatf("hold%0d.sum", i),       64'(sum),       64'(hs));
      chk($sformatf("hold%0d.carry", i),     64'(carry),     64'(hc));
      chk($sformatf("hold%0d.total", i),     64'(total),     64'd22);
    end

    // ---------------- reset mid-burst ----------------
    apply(1'b1, 16'd255, 16'd128, 16'd1);
    apply(1'b1, 16'd65535, 16'd65535, 16'd65535);
    chk("burst.total", 64'(total), 64'd196605);
    in_valid = 1'b1; a = 16'd1000; b = 16'd2000; c = 16'd3000;
    #2 rst = 1'b1;
    #1;
    chk_zero("async_clear");
    @(posedge clk); #1;
    chk_zero("rst_held");
    #2 rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_zero("after_rst_idle");
    apply(1'b1, 16'd10, 16'd5, 16'd7);
    chk("restart.out_valid", 64'(out_valid), 64'd1);
    chk("restart.sum",       64'(sum),       64'd8);
    chk("restart.carry",     64'(carry),     64'd7);
    chk("restart.total",     64'(total),     64'd22);
    apply(1'b0, 16'd0, 16'd0, 16'd0);
    chk("restart.fall", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
